// File: rtl/cache_d_sa_if.sv
// Processor-side and memory-side bus bundle for the set-associative data cache.
// The cache uses the slave modport; the pipeline/memory environment uses master.
interface cache_d_sa_if #(
  parameter int AW          = 30,
  parameter int DW          = 32,
  parameter int BLOCK_WORDS = 4
);
  localparam int MEM_AW = AW - $clog2(BLOCK_WORDS);
  localparam int MEM_DW = DW * BLOCK_WORDS;

  logic              proc_stall;
  logic [AW-1:0]     proc_addr;
  logic              proc_read;
  logic [DW-1:0]     proc_rdata;
  logic              proc_write;
  logic [DW-1:0]     proc_wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_read;
  logic [MEM_DW-1:0] mem_rdata;
  logic              mem_write;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_ready;

  modport slave (
    input  proc_addr, proc_read, proc_write, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output proc_addr, proc_read, proc_write, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cache_d_sa.sv
// Set-associative (1 or 2 ways), write-back, write-allocate data cache.
// Hits complete combinationally; misses run an optional dirty write-back and
// a block refill over a ready-handshaked block-wide memory bus.
module cache_d_sa #(
  parameter int AW          = 30,
  parameter int DW          = 32,
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WAYS        = 2
) (
  input  logic         clk,
  input  logic         proc_reset,
  cache_d_sa_if.slave  bus
);
  localparam int OFS    = $clog2(BLOCK_WORDS);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = AW - OFS - IDX;
  localparam int MEM_DW = DW * BLOCK_WORDS;

  typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t                 state_q, state_d;
  logic [1:0][SETS-1:0]   valid_q, valid_d;
  logic [1:0][SETS-1:0]   dirty_q, dirty_d;
  logic [SETS-1:0]        lru_q, lru_d;
  logic                   vic_q, vic_d;
  // Storage is always two ways wide; way 1 is never selected when WAYS=1.
  logic [TAG-1:0]         tag_q  [2][SETS];
  logic [TAG-1:0]         tag_d  [2][SETS];
  logic [MEM_DW-1:0]      data_q [2][SETS];
  logic [MEM_DW-1:0]      data_d [2][SETS];

  logic [TAG-1:0]         req_tag;
  logic [IDX-1:0]         req_idx;
  logic [OFS-1:0]         req_ofs;
  logic                   req, req_wr;
  logic                   hit, hit_way, victim;
  logic [DW-1:0]          hit_word;

  assign req_tag = bus.proc_addr[AW-1:OFS+IDX];
  assign req_idx = bus.proc_addr[OFS+IDX-1:OFS];
  assign req_ofs = bus.proc_addr[OFS-1:0];
  assign req     = bus.proc_read | bus.proc_write;
  assign req_wr  = bus.proc_write;

  // Tag lookup, word select and victim choice for the current request.
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < 2; w++) begin
      if (w < WAYS && valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      if (req_ofs == w[OFS-1:0]) hit_word = data_q[hit_way][req_idx][w*DW +: DW];
    end
    if (!valid_q[0][req_idx])                 victim = 1'b0;
    else if (WAYS == 2 && !valid_q[1][req_idx]) victim = 1'b1;
    else if (WAYS == 2)                       victim = lru_q[req_idx];
    else                                      victim = 1'b0;
  end

  // Controller next state, line updates and bus outputs.
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    lru_d          = lru_q;
    vic_d          = vic_q;
    tag_d          = tag_q;
    data_d         = data_q;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      S_COMPARE: begin
        if (req && hit) begin
          if (req_wr) begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
              if (req_ofs == w[OFS-1:0]) data_d[hit_way][req_idx][w*DW +: DW] = bus.proc_wdata;
            end
            dirty_d[hit_way][req_idx] = 1'b1;
          end else begin
            bus.proc_rdata = hit_word;
          end
          if (WAYS == 2) lru_d[req_idx] = ~hit_way;
        end else if (req) begin
          bus.proc_stall = 1'b1;
          vic_d          = victim;
          if (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) state_d = S_WRITEBACK;
          else                                                      state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {tag_q[vic_q][req_idx], req_idx};
        bus.mem_wdata  = data_q[vic_q][req_idx];
        if (bus.mem_ready) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = {req_tag, req_idx};
        if (bus.mem_ready) begin
          data_d[vic_q][req_idx]  = bus.mem_rdata;
          tag_d[vic_q][req_idx]   = req_tag;
          valid_d[vic_q][req_idx] = 1'b1;
          dirty_d[vic_q][req_idx] = 1'b0;
          if (WAYS == 2) lru_d[req_idx] = ~vic_q;
          state_d = S_COMPARE;
        end
      end
      default: state_d = S_COMPARE;
    endcase
  end

  // Control state: FSM, valid/dirty/LRU bits and held victim way.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= S_COMPARE;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
      vic_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
      vic_q   <= vic_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_cache_d_sa.sv
// Bench for cache_d_sa: a 2-way and a direct-mapped instance, each with its own
// latency-programmable memory, checked against a behavioural cache model.
module tb_cache_d_sa;
  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  cache_d_sa_if #(.AW(30), .DW(32), .BLOCK_WORDS(4)) b2 ();
  cache_d_sa_if #(.AW(30), .DW(32), .BLOCK_WORDS(4)) b1 ();

  cache_d_sa #(.WAYS(2)) dut2 (.clk(clk), .proc_reset(proc_reset), .bus(b2));
  cache_d_sa #(.WAYS(1)) dut1 (.clk(clk), .proc_reset(proc_reset), .bus(b1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  typedef struct {int s; bit wr; logic [27:0] addr; logic [127:0] data;} txn_t;
  txn_t logq[$];
  logic [127:0] dmem [longint];
  logic [127:0] rmem [longint];
  int mlat [2];
  int mcnt [2];
  logic [27:0] maddr0 [2];

  function automatic longint key(int s, logic [27:0] a);
    return (longint'(s) << 28) | longint'(a);
  endfunction

  function automatic logic [127:0] blk_init(logic [27:0] ba);
    logic [127:0] r;
    logic [31:0] tg;
    tg = 32'(ba >> 2);
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'h100 * tg + 32'(w);
    return r;
  endfunction

  task automatic mem_step(input int s, input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wd, output logic rdy, output logic [127:0] rdat);
    txn_t t;
    rdy = 1'b0;
    rdat = '0;
    if (rd | wr) begin
      chk("mem_rd_wr_exclusive", {127'b0, rd & wr}, 0);
      if (mcnt[s] == 0) maddr0[s] = addr;
      else chk("mem_addr_stable", addr, maddr0[s]);
      mcnt[s]++;
      if (mcnt[s] >= mlat[s]) begin
        rdy = 1'b1;
        mcnt[s] = 0;
        t.s = s; t.wr = wr; t.addr = addr; t.data = wd;
        if (wr) dmem[key(s, addr)] = wd;
        else begin
          rdat = dmem.exists(key(s, addr)) ? dmem[key(s, addr)] : blk_init(addr);
          t.data = rdat;
        end
        logq.push_back(t);
      end
    end else mcnt[s] = 0;
  endtask

  always @(negedge clk) begin : mem_proc
    logic r;
    logic [127:0] d;
    mem_step(0, b2.mem_read, b2.mem_write, b2.mem_addr, b2.mem_wdata, r, d);
    b2.mem_ready = r; b2.mem_rdata = d;
    mem_step(1, b1.mem_read, b1.mem_write, b1.mem_addr, b1.mem_wdata, r, d);
    b1.mem_ready = r; b1.mem_rdata = d;
  end

  // ---------------- reference model ----------------
  bit           m_valid [2][2][4];
  bit           m_dirty [2][2][4];
  logic [25:0]  m_tag   [2][2][4];
  logic [127:0] m_data  [2][2][4];
  int           m_lru   [2][4];

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) begin
        m_lru[s][i] = 0;
        for (int w = 0; w < 2; w++) begin m_valid[s][w][i] = 0; m_dirty[s][w][i] = 0; end
      end
  endtask

  task automatic model_access(input int s, input logic [29:0] a, input bit wr, input logic [31:0] wd,
                              output bit miss, output bit wb, output logic [27:0] wba,
                              output logic [127:0] wbd, output logic [27:0] fa, output logic [31:0] rd);
    int nw, idx, off, way;
    logic [25:0] tg;
    nw = (s == 0) ? 2 : 1;
    idx = int'(a[3:2]); off = int'(a[1:0]); tg = a[29:4]; way = -1;
    miss = 0; wb = 0; wba = '0; wbd = '0; fa = '0; rd = '0;
    for (int w = 0; w < nw; w++) if (m_valid[s][w][idx] && m_tag[s][w][idx] == tg) way = w;
    if (way < 0) begin
      miss = 1;
      for (int w = 0; w < nw; w++) if (!m_valid[s][w][idx] && way < 0) way = w;
      if (way < 0) way = m_lru[s][idx];
      if (m_dirty[s][way][idx]) begin
        wb = 1;
        wba = {m_tag[s][way][idx], a[3:2]};
        wbd = m_data[s][way][idx];
        rmem[key(s, wba)] = wbd;
      end
      fa = a[29:2];
      m_data[s][way][idx] = rmem.exists(key(s, fa)) ? rmem[key(s, fa)] : blk_init(fa);
      m_tag[s][way][idx] = tg; m_valid[s][way][idx] = 1; m_dirty[s][way][idx] = 0;
    end
    if (wr) begin
      m_data[s][way][idx][off*32 +: 32] = wd;
      m_dirty[s][way][idx] = 1;
    end else rd = m_data[s][way][idx][off*32 +: 32];
    if (nw == 2) m_lru[s][idx] = (way == 0) ? 1 : 0;
  endtask

  // ---------------- processor driver ----------------
  task automatic set_proc(input int s, input logic [29:0] a, input bit rd, input bit wr, input logic [31:0] wd);
    if (s == 0) begin b2.proc_addr = a; b2.proc_read = rd; b2.proc_write = wr; b2.proc_wdata = wd; end
    else        begin b1.proc_addr = a; b1.proc_read = rd; b1.proc_write = wr; b1.proc_wdata = wd; end
  endtask

  function automatic logic get_stall(int s);
    return (s == 0) ? b2.proc_stall : b1.proc_stall;
  endfunction

  task automatic run_access(input int s, input logic [29:0] a, input bit rd, input bit wr,
                            input logic [31:0] wd, output int n, output logic [31:0] got);
    bit miss, wb;
    logic [27:0] wba, fa;
    logic [127:0] wbd;
    logic [31:0] erd;
    int exp_n;
    txn_t t;
    model_access(s, a, wr, wd, miss, wb, wba, wbd, fa, erd);
    exp_n = !miss ? 0 : (wb ? 1 + 2 * mlat[s] : 1 + mlat[s]);
    set_proc(s, a, rd, wr, wd);
    n = 0;
    #1;
    while (get_stall(s) && n < 64) begin n++; @(negedge clk); #1; end
    got = (s == 0) ? b2.proc_rdata : b1.proc_rdata;
    chk("stall_cycles", 128'(n), 128'(exp_n));
    chk("proc_rdata", got, (rd && !wr) ? erd : 32'h0);
    @(negedge clk);
    set_proc(s, '0, 0, 0, '0);
    chk("txn_count", 128'(logq.size()), 128'(int'(wb) + int'(miss)));
    if (wb && logq.size() > 0) begin
      t = logq.pop_front();
      chk("wb_is_write", {127'b0, t.wr}, 1);
      chk("wb_addr", t.addr, wba);
      chk("wb_data", t.data, wbd);
    end
    if (miss && logq.size() > 0) begin
      t = logq.pop_front();
      chk("fill_is_read", {127'b0, t.wr}, 0);
      chk("fill_addr", t.addr, fa);
    end
    logq.delete();
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    set_proc(0, '0, 0, 0, '0);
    set_proc(1, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
    model_reset();
    logq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] got;
    logic [29:0] a;
    int op;
    mlat[0] = 3; mlat[1] = 3; mcnt[0] = 0; mcnt[1] = 0;
    b2.mem_ready = 0; b2.mem_rdata = '0; b1.mem_ready = 0; b1.mem_rdata = '0;

    // Reset state
    do_reset();
    #1;
    chk("rst_stall", {127'b0, b2.proc_stall}, 0);
    chk("rst_mem_read", {127'b0, b2.mem_read}, 0);
    chk("rst_mem_write", {127'b0, b2.mem_write}, 0);
    chk("rst_mem_addr", b2.mem_addr, 0);
    chk("rst_mem_wdata", b2.mem_wdata, 0);
    chk("rst_rdata", b2.proc_rdata, 0);
    @(negedge clk);

    // Clean read miss, write hit, dirty eviction
    run_access(0, 30'h10, 1, 0, 0, n, got);
    chk("t1_stall", 128'(n), 4); chk("t1_rdata", got, 32'h100);
    run_access(0, 30'h11, 0, 1, 32'hDEADBEEF, n, got);
    chk("t2_wr_stall", 128'(n), 0);
    run_access(0, 30'h11, 1, 0, 0, n, got);
    chk("t2_rd_stall", 128'(n), 0); chk("t2_rdata", got, 32'hDEADBEEF);
    run_access(0, 30'h20, 1, 0, 0, n, got);
    run_access(0, 30'h30, 1, 0, 0, n, got);
    chk("t3_stall", 128'(n), 7); chk("t3_rdata", got, 32'h300);

    // LRU: hit on tag 1 makes tag 2 the clean victim
    do_reset();
    run_access(0, 30'h10, 1, 0, 0, n, got);
    run_access(0, 30'h20, 1, 0, 0, n, got);
    run_access(0, 30'h10, 1, 0, 0, n, got);
    chk("t4_hit_stall", 128'(n), 0);
    run_access(0, 30'h30, 1, 0, 0, n, got);
    chk("t4_evict_stall", 128'(n), 4);
    run_access(0, 30'h10, 1, 0, 0, n, got);
    chk("t4_keep_stall", 128'(n), 0);
    run_access(0, 30'h20, 1, 0, 0, n, got);
    chk("t4_gone_stall", 128'(n), 4);

    // Reset in the second write-back cycle
    do_reset();
    run_access(0, 30'h10, 0, 1, 32'hCAFE0001, n, got);
    run_access(0, 30'h20, 1, 0, 0, n, got);
    set_proc(0, 30'h30, 1, 0, 0);
    @(negedge clk); #1 chk("t5_wb_cyc1", {127'b0, b2.mem_write}, 1);
    @(negedge clk); #1 chk("t5_wb_cyc2", {127'b0, b2.mem_write}, 1);
    proc_reset = 1'b1;
    set_proc(0, '0, 0, 0, '0);
    @(negedge clk);
    proc_reset = 1'b0;
    #1;
    chk("t5_after_write", {127'b0, b2.mem_write}, 0);
    chk("t5_after_read", {127'b0, b2.mem_read}, 0);
    chk("t5_after_stall", {127'b0, b2.proc_stall}, 0);
    chk("t5_no_txn", 128'(logq.size()), 0);
    model_reset();
    logq.delete();
    run_access(0, 30'h10, 1, 0, 0, n, got);
    chk("t5_reread_stall", 128'(n), 4); chk("t5_reread_data", got, 32'h100);

    // Direct-mapped instance
    do_reset();
    run_access(1, 30'h10, 1, 0, 0, n, got); chk("t6_a_stall", 128'(n), 4);
    run_access(1, 30'h20, 1, 0, 0, n, got); chk("t6_b_stall", 128'(n), 4);
    run_access(1, 30'h10, 1, 0, 0, n, got); chk("t6_c_stall", 128'(n), 4);

    // Randomized traffic with varying memory latency
    for (int s = 0; s < 2; s++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        mlat[s] = int'($urandom_range(1, 4));
        a = 30'(($urandom_range(0, 5) << 4) | ($urandom % 16));
        op = int'($urandom % 3);
        run_access(s, a, op != 1, op != 0, $urandom, n, got);
        if (i % 10 == 0) begin
          #1;
          chk("idle_stall", {127'b0, get_stall(s)}, 0);
          chk("idle_rdata", (s == 0) ? b2.proc_rdata : b1.proc_rdata, 0);
          @(negedge clk);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_d_sa.md
# cache_d_sa

Parametrised set-associative, write-back, write-allocate data cache for the MIPS 5-stage pipeline. It sits between the MEM stage and the data memory port. Hits complete in the access cycle with no stall. Misses stall the pipeline while an optional dirty-victim write-back and a block refill run over a block-wide, ready-handshaked memory bus. Compared with the direct-mapped data cache, it adds configurable ways, sets and block size, plus per-set LRU replacement.

## Interface
- `AW`, default 30: processor word-address width (byte address bits [1:0] already dropped).
- `DW`, default 32: processor data width.
- `SETS`, default 4: number of sets; power of two, ≥2.
- `BLOCK_WORDS`, default 4: words per block; power of two, ≥2.
- `WAYS`, default 2: associativity; legal values 1 or 2.
- Derived widths:
  - `OFS = log2(BLOCK_WORDS)`, `IDX = log2(SETS)`, `TAG = AW-OFS-IDX`.
  - `MEM_AW = AW-OFS`, `MEM_DW = DW*BLOCK_WORDS`.
- `clk`  in  1  clock, all state updates on the rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `proc_stall`  out  1  request not complete this cycle; pipeline holds.
- `proc_addr`  in  AW  word address; fields are tag [AW-1:OFS+IDX], index [OFS+IDX-1:OFS], offset [OFS-1:0].
- `proc_read`  in  1  load request.
- `proc_rdata`  out  DW  load data, valid when `proc_read` is high and `proc_stall` is low.
- `proc_write`  in  1  store request.
- `proc_wdata`  in  DW  store data.
- `mem_addr`  out  MEM_AW  block address {tag,index}.
- `mem_read`  out  1  block refill request.
- `mem_rdata`  in  MEM_DW  refill block; word w occupies bits [w*DW+DW-1:w*DW].
- `mem_write`  out  1  block write-back request.
- `mem_wdata`  out  MEM_DW  victim block, same word packing.
- `mem_ready`  in  1  single-cycle completion pulse for the outstanding request.

## Operation
- Per-line state: valid, dirty, tag, data block. Per-set state: one LRU bit, which marks the way to evict; ignored when WAYS=1.
- FSM states:
  - **COMPARE**: idle/lookup.
    - Hit: lookup is combinational; a read drives `proc_rdata` from the hit way. A write updates the addressed word at the edge and sets dirty. LRU points to the other way. Stall is 0.
    - Miss with a request: stall is 1. Victim selection:
      - First invalid way (way 0 preferred), otherwise the LRU way.
      - Victim valid and dirty → WRITEBACK.
      - Otherwise → ALLOCATE.
  - **WRITEBACK**:
    - `mem_write`=1, `mem_addr`={victim tag,index}, `mem_wdata`=victim block, all held stable.
    - On `mem_ready` → ALLOCATE.
  - **ALLOCATE**:
    - `mem_read`=1, `mem_addr`={request tag,index}, held stable.
    - On `mem_ready`, the victim line is written with `mem_rdata` and the request tag; valid=1, dirty=0.
    - The filled way becomes most-recently-used (LRU points to the other way).
    - → COMPARE, where the held request hits.
- No request: `proc_stall`=0 and state stays COMPARE.
- `proc_read` and `proc_write` both high: treated as a write.
- `proc_rdata` is 0 whenever there is no read hit.
- `mem_ready` outside WRITEBACK/ALLOCATE is ignored.
- `mem_read` and `mem_write` are never high together.

## Timing
- Reset values:
  - State COMPARE.
  - All valid, dirty and LRU bits 0.
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - `proc_stall`=0 while no request is present.
  - Tag/data arrays need not be cleared.
- Reset mid-WRITEBACK or mid-ALLOCATE: abort. The cycle after reset has no memory request, and all lines are invalid. Dirty data is discarded by design.
- Hit latency: 0 stall cycles.
- Memory handshake: memory latency L ≥ 1 means `mem_ready` arrives in the L-th cycle the request is high. The request drops the cycle after `mem_ready`.
- Clean-miss stall: 1 + L cycles.
- Dirty-miss stall: 1 + Lw + Lr cycles.
- The processor holds `proc_addr`, `proc_read`, `proc_write` and `proc_wdata` stable while `proc_stall`=1.
- `proc_stall` is combinational from COMPARE-state lookup and high in every WRITEBACK and ALLOCATE cycle.

## Test plan
All scenarios use defaults (AW=30, SETS=4, BLOCK_WORDS=4, WAYS=2), a memory model with L=3, and refill data word w = 0x100*tag + w.
- **Clean read miss.** Reset, then read `proc_addr`=0x10 (tag 1, idx 0, word 0).
  - `mem_read`=1 with `mem_addr`=0x4 for 3 cycles, `mem_write`=0.
  - `proc_stall` high exactly 4 cycles.
  - Then `proc_rdata`=0x100 with stall 0.
- **Write hit.** Write 0x11 with 0xDEADBEEF.
  - No stall and no memory request.
  - A following read of 0x11 returns 0xDEADBEEF with 0 stall.
- **Dirty eviction.** Read 0x20 (fills way 1), then read 0x30 (idx 0, tag 3).
  - `mem_write` with `mem_addr`=0x4 and `mem_wdata`[63:32]=0xDEADBEEF first.
  - Then `mem_read` with `mem_addr`=0xC.
  - Stall 7 cycles; `proc_rdata`=0x300.
- **LRU.** After reset, fill tag 1 and tag 2 in idx 0, read 0x10 (hit), then read 0x30.
  - Tag 2 is evicted with no `mem_write`.
  - A later read of 0x10 hits and a read of 0x20 misses.
- **Reset mid write-back.** Assert `proc_reset` in the 2nd WRITEBACK cycle.
  - Next cycle: `mem_write`=0 and `proc_stall`=0 with the request deasserted.
  - Re-reading 0x10 misses with refill only.
- **Direct-mapped.** WAYS=1: reads 0x10, 0x20, 0x10 all miss, each with a 4-cycle stall.
